// File: rtl/context_switch_scheduler_pkg.sv
// Shared parameters for the context-switch scheduler: array stage codes,
// window command encodings and the switch FSM state type.
package context_switch_scheduler_pkg;

    localparam int STAGE_WIDTH = 3;

    localparam logic [STAGE_WIDTH-1:0] STAGE_IDLE          = 3'd0;
    localparam logic [STAGE_WIDTH-1:0] STAGE_WRITE_TO_MEM  = 3'd1;
    localparam logic [STAGE_WIDTH-1:0] STAGE_READ_FROM_MEM = 3'd2;

    localparam logic [1:0] WINDOW_CMD_NONE         = 2'd0;
    localparam logic [1:0] WINDOW_CMD_RESET_ROOTS  = 2'd1;
    localparam logic [1:0] WINDOW_CMD_PEELING      = 2'd2;
    localparam logic [1:0] WINDOW_CMD_RESULT_VALID = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SAVE  = 2'd1,
        ST_FETCH = 2'd2,
        ST_LOAD  = 2'd3
    } sw_state_e;

endpackage

// File: rtl/context_switch_scheduler_if.sv
// Switch handshake, window command and context-memory/array control bundle.
interface context_switch_scheduler_if
    import context_switch_scheduler_pkg::*;
#(
    parameter int NUM_CONTEXTS = 4
);
    localparam int CTX_W = $clog2(NUM_CONTEXTS);

    logic                   switch_req;
    logic                   switch_skip;
    logic [1:0]             window_cmd;
    logic                   switch_ack;
    logic                   switch_done;
    logic [STAGE_WIDTH-1:0] ctx_stage;
    logic                   mem_we;
    logic [CTX_W-1:0]       mem_addr;
    logic                   do_not_store;
    logic [CTX_W-1:0]       cur_ctx;
    logic [CTX_W-1:0]       ctx_min;
    logic [CTX_W-1:0]       ctx_max;

    modport master (
        output switch_req, switch_skip, window_cmd,
        input  switch_ack, switch_done, ctx_stage, mem_we, mem_addr,
               do_not_store, cur_ctx, ctx_min, ctx_max
    );

    modport slave (
        input  switch_req, switch_skip, window_cmd,
        output switch_ack, switch_done, ctx_stage, mem_we, mem_addr,
               do_not_store, cur_ctx, ctx_min, ctx_max
    );

endinterface

// File: rtl/context_switch_scheduler_ctx_window_tracker.sv
// Active context window and wrap-around successor of the resident context.
// Window logic is built only when CONTEXT_WINDOW_EN is defined; otherwise the
// window is the full range and the successor is a plain modulo-N increment.
module ctx_window_tracker
    import context_switch_scheduler_pkg::*;
#(
    parameter  int NUM_CONTEXTS = 4,
    localparam int CTX_W        = $clog2(NUM_CONTEXTS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       window_cmd_i,
    input  logic [CTX_W-1:0] cur_ctx_i,
    output logic [CTX_W-1:0] nxt_ctx_o,
    output logic [CTX_W-1:0] ctx_min_o,
    output logic [CTX_W-1:0] ctx_max_o
);
    localparam logic [CTX_W-1:0] HALF_C    = CTX_W'(NUM_CONTEXTS / 2);
    localparam logic [CTX_W-1:0] HALF_M1_C = CTX_W'(NUM_CONTEXTS / 2 - 1);
    localparam logic [CTX_W-1:0] LAST_C    = CTX_W'(NUM_CONTEXTS - 1);

`ifdef CONTEXT_WINDOW_EN
    logic [CTX_W-1:0] min_q, min_d, max_q, max_d;
    logic             full_q, full_d, not_first_q, not_first_d;

    // Window bounds and RESET_ROOTS history, reset to the low half.
    always_ff @(posedge clk) begin
        if (reset) begin
            min_q       <= '0;
            max_q       <= HALF_M1_C;
            full_q      <= 1'b0;
            not_first_q <= 1'b0;
        end else begin
            // NOTE: registers take non-blocking assignments so every flop samples pre-edge values.
            min_q       <= min_d;
            max_q       <= max_d;
            full_q      <= full_d;
            not_first_q <= not_first_d;
        end
    end

    // Window commands only take effect at a half boundary (context 0 or HALF).
    always_comb begin
        // NOTE: defaults first so no path through this block leaves a latch.
        min_d       = min_q;
        max_d       = max_q;
        full_d      = full_q;
        not_first_d = not_first_q;
        if (cur_ctx_i == '0 || cur_ctx_i == HALF_C) begin
            case (window_cmd_i)
                WINDOW_CMD_RESET_ROOTS: begin
                    if (!not_first_q) begin
                        min_d       = HALF_C;
                        max_d       = LAST_C;
                        not_first_d = 1'b1;
                    end else if (full_q) begin
                        min_d  = (cur_ctx_i == '0) ? HALF_C : '0;
                        max_d  = (cur_ctx_i == '0) ? LAST_C : HALF_M1_C;
                        full_d = 1'b0;
                    end else begin
                        min_d  = '0;
                        max_d  = LAST_C;
                        full_d = 1'b1;
                    end
                end
                WINDOW_CMD_PEELING: begin
                    min_d = (cur_ctx_i < HALF_C) ? '0 : HALF_C;
                    max_d = (cur_ctx_i < HALF_C) ? HALF_M1_C : LAST_C;
                end
                WINDOW_CMD_RESULT_VALID: begin
                    min_d = '0;
                    max_d = LAST_C;
                end
                default: ;
            endcase
        end
    end

    // Successor: wrap at the window top, then at the physical top.
    always_comb begin
        if (NUM_CONTEXTS == 2)
            nxt_ctx_o = ~cur_ctx_i;
        else if (cur_ctx_i == max_q)
            nxt_ctx_o = min_q;
        else if (cur_ctx_i == LAST_C)
            nxt_ctx_o = '0;
        else
            nxt_ctx_o = cur_ctx_i + CTX_W'(1);
    end

    assign ctx_min_o = min_q;
    assign ctx_max_o = max_q;
`else
    logic unused_window_inputs;
    assign unused_window_inputs = ^{clk, reset, window_cmd_i, HALF_C, HALF_M1_C};

    assign ctx_min_o = '0;
    assign ctx_max_o = LAST_C;
    assign nxt_ctx_o = cur_ctx_i + CTX_W'(1);
`endif

endmodule

// File: rtl/context_switch_scheduler.sv
// Context-switch sequencer: SAVE -> FETCH -> LOAD on each accepted request,
// owning the shared context-memory address and the array stage/suppress flags.
// Optional window logic lives in ctx_window_tracker under CONTEXT_WINDOW_EN.
module context_switch_scheduler
    import context_switch_scheduler_pkg::*;
#(
    parameter int NUM_CONTEXTS = 4
) (
    input logic                  clk,
    input logic                  reset,
    context_switch_scheduler_if.slave bus
);
    localparam int CTX_W = $clog2(NUM_CONTEXTS);

    sw_state_e        state_q, state_d;
    logic             skip_q, skip_d;
    logic [CTX_W-1:0] cur_ctx_q, cur_ctx_d;
    logic [CTX_W-1:0] nxt_q, nxt_d;
    logic [CTX_W-1:0] nxt_ctx;

    ctx_window_tracker #(.NUM_CONTEXTS(NUM_CONTEXTS)) u_window (
        .clk          (clk),
        .reset        (reset),
        .window_cmd_i (bus.window_cmd),
        .cur_ctx_i    (cur_ctx_q),
        .nxt_ctx_o    (nxt_ctx),
        .ctx_min_o    (bus.ctx_min),
        .ctx_max_o    (bus.ctx_max)
    );

    // FSM state, latched skip flag, resident context and latched restore target.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            skip_q    <= 1'b0;
            cur_ctx_q <= '0;
            nxt_q     <= '0;
        end else begin
            state_q   <= state_d;
            skip_q    <= skip_d;
            cur_ctx_q <= cur_ctx_d;
            nxt_q     <= nxt_d;
        end
    end

    // Next-state and per-stage outputs; strobes are gated by reset so an
    // aborted switch neither writes nor signals completion.
    always_comb begin
        state_d          = state_q;
        skip_d           = skip_q;
        cur_ctx_d        = cur_ctx_q;
        nxt_d            = nxt_q;
        bus.switch_ack   = 1'b0;
        bus.switch_done  = 1'b0;
        bus.ctx_stage    = STAGE_IDLE;
        bus.mem_we       = 1'b0;
        bus.mem_addr     = '0;
        bus.do_not_store = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.switch_req && !reset) begin
                    bus.switch_ack = 1'b1;
                    skip_d         = bus.switch_skip;
                    state_d        = ST_SAVE;
                end
            end
            ST_SAVE: begin
                bus.ctx_stage    = STAGE_WRITE_TO_MEM;
                bus.mem_addr     = cur_ctx_q;
                bus.mem_we       = !skip_q && !reset;
                bus.do_not_store = skip_q;
                // Restore target is frozen here so a window command in FETCH cannot move it.
                nxt_d            = skip_q ? cur_ctx_q : nxt_ctx;
                state_d          = ST_FETCH;
            end
            ST_FETCH: begin
                bus.mem_addr     = nxt_q;
                bus.do_not_store = skip_q;
                state_d          = ST_LOAD;
            end
            ST_LOAD: begin
                bus.ctx_stage    = STAGE_READ_FROM_MEM;
                bus.mem_addr     = nxt_q;
                bus.do_not_store = skip_q;
                bus.switch_done  = !reset;
                cur_ctx_d        = nxt_q;
                state_d          = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.cur_ctx = cur_ctx_q;

endmodule

// File: tb/tb_context_switch_scheduler.sv
// Randomized scoreboard bench for context_switch_scheduler (N=4).
module tb_context_switch_scheduler;
    import context_switch_scheduler_pkg::*;

    localparam int N    = 4;
    localparam int HALF = N / 2;
`ifdef CONTEXT_WINDOW_EN
    localparam bit WINDOW_EN = 1'b1;
`else
    localparam bit WINDOW_EN = 1'b0;
`endif

    typedef struct {
        int save_addr;
        int we;
        int dns;
        int restore_addr;
        int wmin;
        int wmax;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   gap;
    exp_t exp_q[$];

    // Reference model state: resident context and window as the rules describe them.
    int m_cur, m_min, m_max;
    bit m_full, m_nf;

    context_switch_scheduler_if #(.NUM_CONTEXTS(N)) bus ();
    context_switch_scheduler #(.NUM_CONTEXTS(N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        m_cur  = 0;
        m_full = 1'b0;
        m_nf   = 1'b0;
        m_min  = 0;
        m_max  = WINDOW_EN ? HALF - 1 : N - 1;
    endtask

    function automatic int model_next(input int c);
        if (!WINDOW_EN) return (c + 1) % N;
        if (c == m_max) return m_min;
        if (c == N - 1) return 0;
        return c + 1;
    endfunction

    task automatic model_cmd(input int cmd);
        if (!WINDOW_EN || cmd == 0) return;
        if (m_cur != 0 && m_cur != HALF) return;
        case (cmd)
            1: begin
                if (!m_nf) begin
                    m_min = HALF; m_max = N - 1; m_nf = 1'b1;
                end else if (m_full) begin
                    m_min = (m_cur == 0) ? HALF : 0;
                    m_max = (m_cur == 0) ? N - 1 : HALF - 1;
                    m_full = 1'b0;
                end else begin
                    m_min = 0; m_max = N - 1; m_full = 1'b1;
                end
            end
            2: begin
                m_min = (m_cur < HALF) ? 0 : HALF;
                m_max = (m_cur < HALF) ? HALF - 1 : N - 1;
            end
            default: begin
                m_min = 0; m_max = N - 1;
            end
        endcase
    endtask

    // Monitor: collects SAVE-stage observations and scores each completed switch.
    int ack_cyc   = -1;
    bit save_seen = 1'b0;
    int s_addr, s_we, s_dns;
    bit pend_cur  = 1'b0;
    int pend_val;

    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            ack_cyc   = -1;
            save_seen = 1'b0;
            pend_cur  = 1'b0;
        end else begin
            if (pend_cur) begin
                check("cur_ctx_after_load", bus.cur_ctx, pend_val);
                pend_cur = 1'b0;
            end
            if (bus.switch_ack) begin
                ack_cyc   = cyc;
                save_seen = 1'b0;
            end
            if (bus.ctx_stage == STAGE_WRITE_TO_MEM) begin
                save_seen = 1'b1;
                s_addr    = bus.mem_addr;
                s_we      = bus.mem_we;
                s_dns     = bus.do_not_store;
            end
            if (bus.mem_we) check("mem_we_only_in_save", bus.ctx_stage, STAGE_WRITE_TO_MEM);
            if (bus.switch_done) begin
                check("done_has_expectation", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("done_latency", cyc - ack_cyc, 3);
                    check("save_seen", save_seen, 1);
                    check("save_addr", s_addr, e.save_addr);
                    check("save_we", s_we, e.we);
                    check("save_do_not_store", s_dns, e.dns);
                    check("load_stage", bus.ctx_stage, STAGE_READ_FROM_MEM);
                    check("load_addr", bus.mem_addr, e.restore_addr);
                    check("load_do_not_store", bus.do_not_store, e.dns);
                    check("ctx_min", bus.ctx_min, e.wmin);
                    check("ctx_max", bus.ctx_max, e.wmax);
                    pend_cur = 1'b1;
                    pend_val = e.restore_addr;
                end
            end
        end
    end

    // Wait (bounded) for the request to be acknowledged; called just after a posedge.
    task automatic wait_ack(output bit ok);
        int guard = 0;
        #1;
        while (!bus.switch_ack && guard < 8) begin
            @(posedge clk); #1;
            guard++;
        end
        ok = bus.switch_ack;
        if (!ok) check("switch_ack_seen", bus.switch_ack, 1);
    endtask

    // One full switch; fetch_cmd is a window command injected in the FETCH cycle.
    task automatic do_switch(input bit skip, input int fetch_cmd);
        exp_t e;
        bit   ok;
        e.save_addr    = m_cur;
        e.we           = skip ? 0 : 1;
        e.dns          = skip ? 1 : 0;
        e.restore_addr = skip ? m_cur : model_next(m_cur);
        model_cmd(fetch_cmd);
        e.wmin = m_min;
        e.wmax = m_max;
        exp_q.push_back(e);
        bus.switch_req  = 1'b1;
        bus.switch_skip = skip;
        wait_ack(ok);
        if (!ok) begin
            bus.switch_req = 1'b0;
            e = exp_q.pop_back();
            return;
        end
        @(posedge clk); #1;
        bus.switch_req  = 1'b0;
        bus.switch_skip = 1'b0;
        @(posedge clk); #1;
        bus.window_cmd = 2'(fetch_cmd);
        @(posedge clk); #1;
        bus.window_cmd = 2'd0;
        @(posedge clk); #1;
        m_cur = e.restore_addr;
    endtask

    // Window command issued while idle.
    task automatic idle_cmd(input int cmd);
        bus.window_cmd = 2'(cmd);
        model_cmd(cmd);
        @(posedge clk); #1;
        bus.window_cmd = 2'd0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit ok;
        bus.switch_req  = 1'b0;
        bus.switch_skip = 1'b0;
        bus.window_cmd  = 2'd0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        @(negedge clk);
        check("reset_ctx_stage", bus.ctx_stage, STAGE_IDLE);
        check("reset_cur_ctx", bus.cur_ctx, 0);
        check("reset_mem_we", bus.mem_we, 0);
        check("reset_mem_addr", bus.mem_addr, 0);
        check("reset_do_not_store", bus.do_not_store, 0);
        check("reset_switch_ack", bus.switch_ack, 0);
        check("reset_switch_done", bus.switch_done, 0);
        check("reset_ctx_min", bus.ctx_min, m_min);
        check("reset_ctx_max", bus.ctx_max, m_max);
        @(posedge clk); #1;

        // Plain wrap order, then RESET_ROOTS at context 0, then a skipped switch.
        repeat (4) do_switch(1'b0, 0);
        idle_cmd(1);
        repeat (4) do_switch(1'b0, 0);
        do_switch(1'b1, 0);

        // Reset during FETCH aborts the switch.
        bus.switch_req = 1'b1;
        wait_ack(ok);
        @(posedge clk); #1;
        bus.switch_req = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
        @(negedge clk);
        check("abort_ctx_stage", bus.ctx_stage, STAGE_IDLE);
        check("abort_cur_ctx", bus.cur_ctx, 0);
        check("abort_mem_we", bus.mem_we, 0);
        check("abort_ctx_min", bus.ctx_min, m_min);
        check("abort_ctx_max", bus.ctx_max, m_max);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("abort_no_switch_done", bus.switch_done, 0);
        end
        @(posedge clk); #1;

        // Three RESET_ROOTS at context 0.
        for (int i = 0; i < 3; i++) begin
            idle_cmd(1);
            @(negedge clk);
            check("rr_ctx_min", bus.ctx_min, m_min);
            check("rr_ctx_max", bus.ctx_max, m_max);
            @(posedge clk); #1;
        end

        // Randomized traffic with idle and in-FETCH window commands.
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 2) == 0) idle_cmd($urandom_range(1, 3));
            gap = $urandom_range(0, 2);
            repeat (gap) begin @(posedge clk); #1; end
            do_switch($urandom_range(0, 4) == 0,
                      ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
        end

        repeat (4) @(posedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/context_switch_scheduler.md
# context_switch_scheduler

Sequences context switches for the multi-context PE/link arrays. On each accepted switch request it runs a fixed save/restore stage sequence. It owns the shared context-memory address pair (write = context being saved, read = context being restored). It maintains the active context window (low half, high half or full range) that decides the wrap-around order. It sits next to the global stage controller and drives the context-related stage, the memory addresses and the store-suppress flag to every link and PE memory in a block.

## Interface
- `NUM_CONTEXTS`, 4: contexts per memory; power of two, ≥2.
- `CTX_W`, `$clog2(NUM_CONTEXTS)`: context address width; derived, not overridden.
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high reset.
- `switch_req`  in  1  request a context switch; held until `switch_ack`.
- `switch_skip`  in  1  sampled with the accepted request; 1 means do not save the current context.
- `window_cmd`  in  2  window command: 0 none, 1 RESET_ROOTS event, 2 PEELING event, 3 RESULT_VALID event; single-cycle.
- `switch_ack`  out  1  one-cycle pulse when a request is accepted.
- `switch_done`  out  1  one-cycle pulse when restored data is valid at the array.
- `ctx_stage`  out  STAGE_WIDTH  the stage the array sees: `STAGE_WRITE_TO_MEM` or `STAGE_READ_FROM_MEM` during a switch, `STAGE_IDLE` otherwise.
- `mem_we`  out  1  context-memory write enable.
- `mem_addr`  out  CTX_W  shared read/write address.
- `do_not_store`  out  1  store-suppress flag to the arrays.
- `cur_ctx`  out  CTX_W  context currently resident in the array.
- `ctx_min`, `ctx_max`  out  CTX_W  active window bounds.

## Operation
- FSM states:
  - IDLE: when `switch_req`=1, pulse `switch_ack`, latch `switch_skip` into `skip_q`, go to SAVE.
  - SAVE (1 cycle):
    - `ctx_stage`=WRITE_TO_MEM.
    - `mem_addr`=`cur_ctx`.
    - `mem_we`=!`skip_q`.
    - `do_not_store`=`skip_q`.
  - FETCH (1 cycle): `mem_addr`=`nxt_ctx` (read issued), `mem_we`=0.
  - LOAD (1 cycle):
    - `ctx_stage`=READ_FROM_MEM; the memory output is valid and the arrays capture it.
    - `cur_ctx`<=`nxt_ctx`.
    - Pulse `switch_done`; go to IDLE.
- `nxt_ctx` is computed combinationally from `cur_ctx`, in priority order:
  - if `cur_ctx`==`ctx_max` then `ctx_min`;
  - else if `cur_ctx`==NUM_CONTEXTS-1 then 0;
  - else `cur_ctx`+1.
- For NUM_CONTEXTS=2, `nxt_ctx`=~`cur_ctx`.
- With `skip_q`=1 the context does not advance: `cur_ctx` is unchanged, LOAD restores from `cur_ctx`, and `do_not_store` stays high through LOAD.
- Window update: `window_cmd` is acted on only when `cur_ctx`∈{0, HALF}, where HALF=NUM_CONTEXTS/2. Otherwise it is ignored.
  - RESET_ROOTS, first occurrence after reset: window=[HALF,N-1]; set `not_first`.
  - RESET_ROOTS, later occurrences: if the current window is full, the new window is the opposite half of `cur_ctx` (`cur_ctx`=0 gives [HALF,N-1], otherwise [0,HALF-1]) and `full` is cleared. Otherwise window=[0,N-1] and `full` is set.
  - PEELING: window = the half containing `cur_ctx`.
  - RESULT_VALID: window=[0,N-1].
- Collisions with a switch:
  - A `window_cmd` arriving during a switch is applied in its arrival cycle against the pre-LOAD `cur_ctx`.
  - If it arrives in FETCH, `nxt_ctx` already latched for that switch is not changed.
- Reset values:
  - FSM=IDLE; `cur_ctx`=0; window=[0,HALF-1]; `full`=0; `not_first`=0.
  - All pulses 0; `mem_we`=0; `do_not_store`=0; `ctx_stage`=STAGE_IDLE; `mem_addr`=0.
- A reset asserted mid-switch aborts the switch at the next edge. No write completes after the reset cycle.

## Timing
- Request accepted (ack) at edge T.
- SAVE write occurs at T+1.
- Read address is presented in cycle T+2.
- `switch_done` and array capture happen at T+3.
- Back-to-back: a new request can be accepted in the cycle after `switch_done`, giving a 4-cycle minimum switch period.
- `switch_req` deasserted before ack is simply not serviced.

## Configuration
- `CONTEXT_WINDOW_EN` defined: window logic active as described.
- Not defined: `ctx_min`=0 and `ctx_max`=N-1 are constant, `window_cmd` is ignored, and `nxt_ctx` is a plain modulo-N increment.

## Structure
- Shared package (existing parameters package) holds:
  - the STAGE_* constants and STAGE_WIDTH;
  - the WINDOW_CMD_* encodings;
  - the FSM state enum.
- One sub-module, `ctx_window_tracker`: window registers plus the `nxt_ctx` function. The top level keeps the FSM and address muxing.

## Test plan
- N=4, four switches with no window commands after reset: SAVE addresses 0,1,0,1 (window [0,1]); `cur_ctx` sequence 1,0,1,0.
- `window_cmd`=1 at `cur_ctx`=0, then switches: window [2,3]; `cur_ctx` 1→… continues 2,3,2; `mem_we` high only in SAVE cycles.
- `switch_skip`=1: `mem_we`=0, `do_not_store`=1 for SAVE through LOAD, `cur_ctx` unchanged, `switch_done` still at T+3.
- Two RESET_ROOTS commands at `cur_ctx`=0: window goes [2,3] then full [0,3]. A third at `cur_ctx`=0 gives [2,3].
- Reset asserted in the FETCH cycle: next cycle FSM=IDLE, `cur_ctx`=0, no `switch_done`.
- `CONTEXT_WINDOW_EN` undefined, N=4: eight switches give `cur_ctx` 1,2,3,0,1,2,3,0 regardless of `window_cmd`.
